// File: rtl/rng_roller.sv
`default_nettype none
// ============================================================================
// Module   : rng_roller
// Brief    : LFSR-backed dice roller; republishes values at slowing intervals.
// Revision : 1.0
// ============================================================================
module rng_roller #(
  parameter int          WIDTH       = 4,
  parameter int          TICKS       = 15,
  parameter int          CNT_W       = 32,
  parameter int          INIT_PERIOD = 8388608,
  parameter int          SLOW_NUM    = 9,
  parameter int          SLOW_SHIFT  = 3,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_hold,
  output logic [WIDTH-1:0] o_random_out,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_done
);

  localparam int               c_TICK_W    = (TICKS < 1) ? 1 : $clog2(TICKS + 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_INIT      = CNT_W'(INIT_PERIOD);
  localparam logic [CNT_W-1:0] c_SLOW_NUM  = CNT_W'(SLOW_NUM);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS - 1);
  localparam logic [15:0]      c_LFSR_MASK = 16'hB400;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_ROLL = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_next_state;
  logic [15:0]         r_lfsr;
  logic [15:0]         w_lfsr_next;
  logic                r_start_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_period;
  logic [c_TICK_W-1:0] r_ticks;
  logic [CNT_W-1:0]    w_product;
  logic [CNT_W-1:0]    w_period_next;
  logic                w_start_edge;
  logic                w_run;
  logic                w_at_end;
  logic                w_tick;
  logic                w_final;
  logic [WIDTH-1:0]    r_random;
  logic                r_busy;
  logic                r_tick;
  logic                r_done;

  // Galois step; the zero check only guards against a corrupted register.
  assign w_lfsr_next = (r_lfsr == 16'h0000) ? 16'h0001 :
                       ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000));

  assign w_start_edge = i_start & ~r_start_q;

  // Low CNT_W bits of a product depend only on the low CNT_W bits of the
  // operands, so a CNT_W-wide multiply gives the truncated wide product.
  assign w_product     = (r_period >> SLOW_SHIFT) * c_SLOW_NUM;
  assign w_period_next = (w_product == '0) ? c_CNT_ONE : w_product;

  // Output / event decode
  always_comb begin
    w_run    = 1'b0;
    w_at_end = 1'b0;
    w_tick   = 1'b0;
    w_final  = 1'b0;
    w_run    = (r_state == c_ROLL) & ~w_start_edge & ~i_hold;
    w_at_end = (r_cnt == (r_period - c_CNT_ONE));
    w_tick   = w_run & w_at_end;
    w_final  = w_tick & (r_ticks == c_TICK_LAST);
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (w_start_edge) begin
      w_next_state = c_ROLL;
    end else if (w_final) begin
      w_next_state = c_IDLE;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr    <= SEED;
      r_start_q <= 1'b0;
    end else begin
      r_lfsr    <= w_lfsr_next;
      r_start_q <= i_start;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_ticks  <= '0;
      r_period <= c_INIT;
      r_random <= '0;
    end else if (w_start_edge) begin
      r_cnt    <= '0;
      r_ticks  <= '0;
      r_period <= c_INIT;
    end else if (w_run) begin
      if (w_at_end) begin
        r_cnt    <= '0;
        r_ticks  <= r_ticks + c_TICK_W'(1);
        r_period <= w_period_next;
        r_random <= r_lfsr[WIDTH-1:0];
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_tick <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == c_ROLL);
      r_tick <= w_tick;
      r_done <= w_final;
    end
  end

  assign o_random_out = r_random;
  assign o_busy       = r_busy;
  assign o_tick       = r_tick;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rng_roller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_roller
// Brief    : Directed self-checking bench for rng_roller.
// Revision : 1.0
// ============================================================================
module tb_rng_roller;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0, rst_b_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [3:0] rnd_a, rnd_b;
  logic       busy_a, tick_a, done_a;
  logic       busy_b, tick_b, done_b;
  logic [15:0] m_lfsr, m_prev;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rng_roller #(.WIDTH(4), .TICKS(4), .CNT_W(32), .INIT_PERIOD(16),
               .SLOW_NUM(9), .SLOW_SHIFT(3), .SEED(16'hACE1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_start(start_a), .i_hold(hold_a),
    .o_random_out(rnd_a), .o_busy(busy_a), .o_tick(tick_a), .o_done(done_a));

  rng_roller #(.WIDTH(4), .TICKS(3), .CNT_W(32), .INIT_PERIOD(4),
               .SLOW_NUM(1), .SLOW_SHIFT(3), .SEED(16'hACE1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_start(start_b), .i_hold(hold_b),
    .o_random_out(rnd_b), .o_busy(busy_b), .o_tick(tick_b), .o_done(done_b));

  // Reference LFSR for dut_a; m_prev holds the value seen before the last edge.
  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_l [3];
    exp_l[0] = 16'hE270; exp_l[1] = 16'h7138; exp_l[2] = 16'h389C;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_a = i[0]; start_b = i[0];
      step();
      tests++;
      if ({rnd_a, busy_a, tick_a, done_a} !== 7'd0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0", i, {rnd_a, busy_a, tick_a, done_a});
      end
      tests++;
      if (dut_a.r_lfsr !== 16'hACE1) begin
        fails++;
        $display("FAIL reset_lfsr got=%h exp=ace1", dut_a.r_lfsr);
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (dut_a.r_lfsr !== exp_l[i]) begin
        fails++;
        $display("FAIL lfsr_seq idx=%0d got=%h exp=%h", i, dut_a.r_lfsr, exp_l[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] last;
    logic       et, ed, eb;
    logic [3:0] ev;
    start_a = 1'b1;
    step();
    tests++;
    if ({busy_a, tick_a, done_a} !== 3'b100) begin
      fails++;
      $display("FAIL basic_start got=%b exp=100", {busy_a, tick_a, done_a});
    end
    last = rnd_a;
    for (int i = 1; i <= 75; i++) begin
      if (i == 3) start_a = 1'b0;
      step();
      et = (i == 16) || (i == 34) || (i == 52) || (i == 70);
      ed = (i == 70);
      eb = (i < 70);
      ev = et ? m_prev[3:0] : last;
      last = ev;
      tests++;
      if ({busy_a, tick_a, done_a} !== {eb, et, ed}) begin
        fails++;
        $display("FAIL basic_flags cyc=k+%0d got=%b exp=%b", i, {busy_a, tick_a, done_a}, {eb, et, ed});
      end
      tests++;
      if (rnd_a !== ev) begin
        fails++;
        $display("FAIL basic_value cyc=k+%0d got=%h exp=%h", i, rnd_a, ev);
      end
    end
  endtask

  task automatic test_hold();
    logic et, ed, eb;
    start_a = 1'b1;
    step();
    for (int i = 1; i <= 85; i++) begin
      if (i == 3)  start_a = 1'b0;
      if (i == 5)  hold_a = 1'b1;
      if (i == 15) hold_a = 1'b0;
      step();
      et = (i == 26) || (i == 44) || (i == 62) || (i == 80);
      ed = (i == 80);
      eb = (i < 80);
      tests++;
      if ({busy_a, tick_a, done_a} !== {eb, et, ed}) begin
        fails++;
        $display("FAIL hold_flags cyc=k+%0d got=%b exp=%b", i, {busy_a, tick_a, done_a}, {eb, et, ed});
      end
    end
  endtask

  task automatic test_restart();
    logic et, ed, eb;
    start_a = 1'b1;
    step();
    for (int i = 1; i <= 115; i++) begin
      if (i == 3)  start_a = 1'b0;
      if (i == 40) start_a = 1'b1;
      if (i == 42) start_a = 1'b0;
      step();
      et = (i == 16) || (i == 34) || (i == 56) || (i == 74) || (i == 92) || (i == 110);
      ed = (i == 110);
      eb = (i < 110);
      tests++;
      if ({busy_a, tick_a, done_a} !== {eb, et, ed}) begin
        fails++;
        $display("FAIL restart_flags cyc=k+%0d got=%b exp=%b", i, {busy_a, tick_a, done_a}, {eb, et, ed});
      end
    end
  endtask

  task automatic test_restart_on_final();
    logic et, ed, eb;
    start_a = 1'b1;
    step();
    for (int i = 1; i <= 145; i++) begin
      if (i == 3)  start_a = 1'b0;
      if (i == 70) start_a = 1'b1;
      if (i == 72) start_a = 1'b0;
      step();
      et = (i == 16) || (i == 34) || (i == 52) || (i == 86) || (i == 104) || (i == 122) || (i == 140);
      ed = (i == 140);
      eb = (i < 140);
      tests++;
      if ({busy_a, tick_a, done_a} !== {eb, et, ed}) begin
        fails++;
        $display("FAIL final_restart_flags cyc=k+%0d got=%b exp=%b", i, {busy_a, tick_a, done_a}, {eb, et, ed});
      end
    end
  endtask

  task automatic test_clamp_and_reset();
    logic et, ed, eb;
    start_b = 1'b1;
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      et = (i == 4) || (i == 5) || (i == 6);
      ed = (i == 6);
      eb = (i < 6);
      tests++;
      if ({busy_b, tick_b, done_b} !== {eb, et, ed}) begin
        fails++;
        $display("FAIL clamp_flags cyc=k+%0d got=%b exp=%b", i, {busy_b, tick_b, done_b}, {eb, et, ed});
      end
    end
    start_b = 1'b0;
    step();
    start_b = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) step();
    tests++;
    if ({busy_b, tick_b} !== 2'b11) begin
      fails++;
      $display("FAIL clamp_second_tick got=%b exp=11", {busy_b, tick_b});
    end
    #3;
    rst_b_n = 1'b0;
    #1;
    tests++;
    if ({rnd_b, busy_b, tick_b, done_b} !== 7'd0) begin
      fails++;
      $display("FAIL async_reset got=%b exp=0", {rnd_b, busy_b, tick_b, done_b});
    end
    start_b = 1'b0;
    step();
    step();
    rst_b_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({busy_b, tick_b, done_b} !== 3'b000) begin
        fails++;
        $display("FAIL post_reset_idle cyc=%0d got=%b exp=000", i, {busy_b, tick_b, done_b});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    for (int i = 0; i < 3; i++) step();
    test_hold();
    for (int i = 0; i < 3; i++) step();
    test_restart();
    for (int i = 0; i < 3; i++) step();
    test_restart_on_final();
    test_clamp_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
